crc_field: RTL and testbench
============================

# crc_field

Serial CRC-15 stage of the CAN data-frame transmitter. It sits directly upstream of the ACK field stage. While the frame is being built it accumulates the CAN CRC-15 over every de-stuffed bit from SOF through the data field. After `data_complete` it shifts the 15-bit CRC out MSB first, then sends the recessive CRC delimiter. It then holds `crc_complete` high, and the ACK stage uses that level to start the ACK slot.

## Interface
Parameters:
- `CRC_WIDTH`, 15: CRC register width. Fixed by CAN; kept as a parameter for bench visibility only.
- `CRC_POLY`, 15'h4599: CAN generator polynomial, x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  block enable; low acts as a synchronous clear to IDLE.
- `sample_point`  in  1  one-cycle bit-timing strobe.
- `frame_start`  in  1  one-cycle pulse at SOF; clears the CRC and starts accumulation.
- `bit_in`  in  1  current frame bit (de-stuffed) to fold into the CRC.
- `bit_in_valid`  in  1  `bit_in` is a CRC-covered bit at this sample point.
- `data_complete`  in  1  the data field has finished; start CRC transmission.
- `rx_bit`  in  1  bus readback bit; used only with `CRC_CHECK_EN`.
- `crc_bit`  out  1  serial CRC or delimiter bit to the bus; 1 = recessive.
- `bit_counter`  out  4  number of CRC-sequence bits sent so far (0..15).
- `crc_value`  out  15  running or frozen CRC register.
- `crc_complete`  out  1  the CRC field and its delimiter have been sent.
- `crc_error`  out  1  sticky readback mismatch (`CRC_CHECK_EN` only).

## Operation
States (3-bit enum): IDLE, ACCUMULATE, TRANSMIT_CRC, TRANSMIT_DELIM, COMPLETE.

Transitions:
- `frame_start` from any state goes to ACCUMULATE and sets `crc_value` = 0, `bit_counter` = 0, `crc_complete` = 0, `crc_error` = 0. It has the highest priority after reset and `enable`.
- ACCUMULATE: on each cycle with `sample_point && bit_in_valid`, nxt = `bit_in` ^ `crc_value[14]`, then `crc_value` = {`crc_value[13:0]`,0} ^ (nxt ? `CRC_POLY` : 0).
- ACCUMULATE goes to TRANSMIT_CRC on `data_complete`. If a valid bit arrives in the same cycle, it is folded in before the snapshot. The shift register is loaded with the post-update CRC.
- TRANSMIT_CRC: `crc_bit` = shift register bit 14. On each `sample_point` the register shifts left by one and `bit_counter` increments. On the 15th sample point the state goes to TRANSMIT_DELIM with `bit_counter` = 15.
- TRANSMIT_DELIM: `crc_bit` = 1. On `sample_point` the state goes to COMPLETE and `crc_complete` is set.
- COMPLETE: `crc_complete` stays high and `crc_bit` = 1 until `frame_start`, `enable` low, or reset.
- IDLE: leaves only on `frame_start`. `data_complete` is ignored in IDLE, COMPLETE and both transmit states.

Other rules:
- `crc_value` is frozen from the `data_complete` snapshot onward. `bit_in_valid` is ignored outside ACCUMULATE.
- `crc_bit` is 1 in every state except TRANSMIT_CRC.

## Timing
- Reset values: state IDLE, `crc_bit` = 1, `bit_counter` = 0, `crc_value` = 0, `crc_complete` = 0, `crc_error` = 0.
- `enable` low at a clock edge restores the same values, including in the middle of transmission.
- All state and outputs are registered except `crc_bit`, which is decoded from state and shift-register registers with no input-to-output combinational path.
- CRC update latency is 1 clock: `crc_value` reflects a bit on the cycle after its sample point.
- The first CRC bit appears on `crc_bit` one clock after `data_complete`.
- Each following bit changes one clock after its `sample_point`.
- `crc_complete` rises one clock after the delimiter's `sample_point`. It is a level, not a pulse.
- Total CRC field length is 16 sample points after `data_complete`.
- Simultaneous `frame_start` and `sample_point`: the frame is cleared and the bit is not accumulated.

## Configuration
Macro `CRC_CHECK_EN`.

With the macro defined:
- In TRANSMIT_CRC and TRANSMIT_DELIM, each `sample_point` with `rx_bit` != `crc_bit` sets `crc_error` one clock later.
- `crc_error` is sticky until `frame_start`, `enable` low, or reset.
- It does not alter the state flow.

Without the macro:
- `rx_bit` is unused.
- `crc_error` is tied to 0.
- The comparator logic is not compiled.

## Structure
- The shared CAN frame package holds `CAN_CRC_POLY`, `CAN_CRC_WIDTH` and the `crc_state_t` enum.
- The package also holds `crc15_next(crc, bit)` as a package function so receive-side logic can reuse it.
- One natural sub-module, `crc15_engine`: accumulator register with clear, update-enable and freeze inputs.
- The FSM, shift register and counter stay in `crc_field`.

## Test plan
- **Single bit:** `frame_start`, then one valid bit 1, then `data_complete` -> `crc_value` = 15'h4599. `crc_bit` sequence = 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1, then delimiter 1. `crc_complete` goes high and stays high.
- **Two bits:** bits 1,0 -> `crc_value` = 15'h4EAB. Bits 0,0,0 -> `crc_value` = 0, 15 zero CRC bits sent, `bit_counter` ends at 15.
- **Same-cycle snapshot:** `data_complete` in the same cycle as valid bit 1 from a cleared CRC -> the transmitted CRC is 15'h4599.
- **Mid-transmit abort:** `enable` low after 7 CRC bits -> next clock IDLE, `crc_bit` = 1, `bit_counter` = 0. A later `data_complete` without `frame_start` is ignored.
- **Async reset:** `reset` asserted mid-TRANSMIT_CRC between edges -> outputs take their reset values immediately. After release, `frame_start` restarts cleanly.
- **Readback check (`CRC_CHECK_EN`):** force `rx_bit` = 0 during a recessive CRC bit -> `crc_error` = 1 one clock later and held through COMPLETE. The next `frame_start` clears it.

Source files
------------

// File: rtl/crc_field_pkg.sv
// rtl/crc_field_pkg.sv - shared CAN frame constants, CRC FSM state type and CRC-15 step function
package crc_field_pkg;

  localparam int          CAN_CRC_WIDTH = 15;
  localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ACCUMULATE     = 3'd1,
    TRANSMIT_CRC   = 3'd2,
    TRANSMIT_DELIM = 3'd3,
    COMPLETE       = 3'd4
  } crc_state_t;

  // One serial CRC-15 step; receive-side logic folds bits with the same function.
  function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic b);
    logic nxt;
    nxt = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (nxt ? CAN_CRC_POLY : 15'h0);
  endfunction

endpackage

// File: rtl/crc_field_crc15_engine.sv
// rtl/crc_field_crc15_engine.sv - serial CRC accumulator with clear, update-enable and freeze
module crc15_engine #(
  parameter int                   W    = 15,
  parameter logic [W-1:0]         POLY = 15'h4599
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         update,
  input  logic         freeze,
  input  logic         bit_in,
  output logic [W-1:0] crc_next,
  output logic [W-1:0] crc_value
);

  logic [W-1:0] crc_q;
  logic [W-1:0] crc_d;
  logic         nxt;

  always_comb begin
    crc_d = crc_q;
    nxt   = bit_in ^ crc_q[W-1];
    if (clear) begin
      crc_d = '0;
    end else if (update && !freeze) begin
      crc_d = {crc_q[W-2:0], 1'b0} ^ (nxt ? POLY : '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  // Exposed so the transmitter can snapshot a bit folded in the same cycle.
  assign crc_next  = crc_d;
  assign crc_value = crc_q;

endmodule

// File: rtl/crc_field.sv
// rtl/crc_field.sv - CAN CRC-15 field transmitter; readback comparator under CRC_CHECK_EN
module crc_field
  import crc_field_pkg::*;
#(
  parameter int                     CRC_WIDTH = CAN_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0]   CRC_POLY  = CAN_CRC_POLY
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sample_point,
  input  logic                 frame_start,
  input  logic                 bit_in,
  input  logic                 bit_in_valid,
  input  logic                 data_complete,
  input  logic                 rx_bit,
  output logic                 crc_bit,
  output logic [3:0]           bit_counter,
  output logic [CRC_WIDTH-1:0] crc_value,
  output logic                 crc_complete,
  output logic                 crc_error
);

  crc_state_t           state_q, state_d;
  logic [CRC_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 complete_q, complete_d;
  logic [CRC_WIDTH-1:0] crc_next;
  logic                 crc_clear;

  assign crc_clear = !enable || frame_start;

  crc15_engine #(
    .W    (CRC_WIDTH),
    .POLY (CRC_POLY)
  ) u_engine (
    .clock     (clock),
    .reset     (reset),
    .clear     (crc_clear),
    .update    (sample_point && bit_in_valid),
    .freeze    (state_q != ACCUMULATE),
    .bit_in    (bit_in),
    .crc_next  (crc_next),
    .crc_value (crc_value)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    complete_d = complete_q;
    if (!enable) begin
      state_d    = IDLE;
      shift_d    = '0;
      cnt_d      = 4'd0;
      complete_d = 1'b0;
    end else if (frame_start) begin
      state_d    = ACCUMULATE;
      shift_d    = '0;
      cnt_d      = 4'd0;
      complete_d = 1'b0;
    end else begin
      case (state_q)
        ACCUMULATE: begin
          if (data_complete) begin
            state_d = TRANSMIT_CRC;
            shift_d = crc_next;
          end
        end
        TRANSMIT_CRC: begin
          if (sample_point) begin
            shift_d = {shift_q[CRC_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd14) state_d = TRANSMIT_DELIM;
          end
        end
        TRANSMIT_DELIM: begin
          if (sample_point) begin
            state_d    = COMPLETE;
            complete_d = 1'b1;
          end
        end
        COMPLETE: ;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= 4'd0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
    end
  end

  assign crc_bit      = (state_q == TRANSMIT_CRC) ? shift_q[CRC_WIDTH-1] : 1'b1;
  assign bit_counter  = cnt_q;
  assign crc_complete = complete_q;

`ifdef CRC_CHECK_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q;
    if (crc_clear) begin
      error_d = 1'b0;
    end else if (sample_point && (rx_bit != crc_bit) &&
                 (state_q == TRANSMIT_CRC || state_q == TRANSMIT_DELIM)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign crc_error = error_q;
`else
  logic unused_rx_bit;
  assign unused_rx_bit = rx_bit;
  assign crc_error     = 1'b0;
`endif

endmodule

// File: tb/tb_crc_field.sv
// tb/tb_crc_field.sv - directed self-checking bench for crc_field
module tb_crc_field;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        sample_point = 1'b0;
  logic        frame_start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_in_valid = 1'b0;
  logic        data_complete = 1'b0;
  logic        rx_bit = 1'b1;
  logic        crc_bit;
  logic [3:0]  bit_counter;
  logic [14:0] crc_value;
  logic        crc_complete;
  logic        crc_error;

  int n_checks = 0;
  int n_fail   = 0;

  crc_field dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_point  (sample_point),
    .frame_start   (frame_start),
    .bit_in        (bit_in),
    .bit_in_valid  (bit_in_valid),
    .data_complete (data_complete),
    .rx_bit        (rx_bit),
    .crc_bit       (crc_bit),
    .bit_counter   (bit_counter),
    .crc_value     (crc_value),
    .crc_complete  (crc_complete),
    .crc_error     (crc_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic feed(input logic b);
    sample_point = 1'b1; bit_in_valid = 1'b1; bit_in = b;
    step();
    sample_point = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic pulse_dc();
    data_complete = 1'b1;
    step();
    data_complete = 1'b0;
  endtask

  task automatic sp(input logic rx);
    rx_bit = rx; sample_point = 1'b1;
    step();
    sample_point = 1'b0; rx_bit = 1'b1;
  endtask

  // Walks the 15 CRC bits and the delimiter; bad_idx selects a bit whose readback is inverted.
  task automatic send_crc(input logic [14:0] exp, input int bad_idx);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("crc_bit[%0d]", i), crc_bit, exp[14-i]);
      sp((i == bad_idx) ? ~exp[14-i] : exp[14-i]);
    end
    chk("cnt_after_15", bit_counter, 4'd15);
    chk("delim_bit", crc_bit, 1'b1);
    chk("complete_before_delim", crc_complete, 1'b0);
    sp(1'b1);
    chk("complete_after_delim", crc_complete, 1'b1);
  endtask

  initial begin
    step();
    step();
    chk("rst_crc_bit", crc_bit, 1'b1);
    chk("rst_cnt", bit_counter, 4'd0);
    chk("rst_crc", crc_value, 15'h0);
    chk("rst_complete", crc_complete, 1'b0);
    chk("rst_error", crc_error, 1'b0);
    reset = 1'b0;
    step();

    // IDLE ignores data_complete
    pulse_dc();
    chk("idle_dc_bit", crc_bit, 1'b1);
    chk("idle_dc_cnt", bit_counter, 4'd0);

    // single bit 1 -> 4599
    start_frame();
    feed(1'b1);
    chk("single_crc", crc_value, 15'h4599);
    pulse_dc();
    chk("first_bit_1clk", crc_bit, 1'b1);
    send_crc(15'h4599, -1);
    step(); step();
    chk("complete_level", crc_complete, 1'b1);
    chk("complete_crc_bit", crc_bit, 1'b1);
    chk("frozen_crc", crc_value, 15'h4599);
    feed(1'b1);
    chk("frozen_after_valid", crc_value, 15'h4599);

    // two bits 1,0 -> 4EAB
    start_frame();
    chk("fs_clear_crc", crc_value, 15'h0);
    chk("fs_clear_complete", crc_complete, 1'b0);
    feed(1'b1);
    feed(1'b0);
    chk("two_bit_crc", crc_value, 15'h4EAB);
    pulse_dc();
    send_crc(15'h4EAB, -1);

    // zeros -> zero CRC
    start_frame();
    feed(1'b0); feed(1'b0); feed(1'b0);
    chk("zero_crc", crc_value, 15'h0);
    pulse_dc();
    send_crc(15'h0, -1);

    // same-cycle valid bit and data_complete
    start_frame();
    sample_point = 1'b1; bit_in_valid = 1'b1; bit_in = 1'b1; data_complete = 1'b1;
    step();
    sample_point = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0; data_complete = 1'b0;
    chk("same_cycle_crc", crc_value, 15'h4599);
    send_crc(15'h4599, -1);

    // frame_start with a sample point: bit is not folded
    frame_start = 1'b1; sample_point = 1'b1; bit_in_valid = 1'b1; bit_in = 1'b1;
    step();
    frame_start = 1'b0; sample_point = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0;
    chk("fs_sp_crc", crc_value, 15'h0);

    // mid-transmit abort via enable
    feed(1'b1);
    pulse_dc();
    for (int i = 0; i < 7; i++) sp(i == 0 || i == 4 || i == 6);
    chk("pre_abort_cnt", bit_counter, 4'd7);
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("abort_bit", crc_bit, 1'b1);
    chk("abort_cnt", bit_counter, 4'd0);
    chk("abort_crc", crc_value, 15'h0);
    pulse_dc();
    sp(1'b1); sp(1'b1);
    chk("abort_dc_ignored_cnt", bit_counter, 4'd0);
    chk("abort_dc_ignored_complete", crc_complete, 1'b0);

    // async reset between edges mid-transmit
    start_frame();
    feed(1'b1);
    pulse_dc();
    sp(1'b1); sp(1'b0); sp(1'b0);
    chk("pre_reset_cnt", bit_counter, 4'd3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", bit_counter, 4'd0);
    chk("async_rst_crc", crc_value, 15'h0);
    chk("async_rst_bit", crc_bit, 1'b1);
    step();
    reset = 1'b0;
    step();
    start_frame();
    feed(1'b1);
    feed(1'b0);
    chk("post_reset_crc", crc_value, 15'h4EAB);

    // readback check
    start_frame();
    feed(1'b1);
    pulse_dc();
`ifdef CRC_CHECK_EN
    sp(1'b0);
    chk("rb_error_set", crc_error, 1'b1);
    for (int i = 1; i < 15; i++) sp(15'h4599 >> (14 - i));
    sp(1'b1);
    chk("rb_complete", crc_complete, 1'b1);
    chk("rb_error_held", crc_error, 1'b1);
    start_frame();
    chk("rb_error_cleared", crc_error, 1'b0);
`else
    send_crc(15'h4599, 0);
    chk("rb_error_tied", crc_error, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
